// File: rtl/or_gate_bist_ctrl_pkg.sv
// Shared definitions for the OR-gate BIST sequencer: FSM states, the
// per-gate pattern order and run-length helpers.
package or_gate_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam int NUM_PAT = 4;
  localparam logic [1:0] PAT_LAST = 2'd3;

  // Pattern order applied to each gate, returned as {a,b}: 11, 01, 10, 00.
  function automatic logic [1:0] pat_ab(input logic [1:0] pat);
    logic [1:0] ab;
    case (pat)
      2'd0:    ab = 2'b11;
      2'd1:    ab = 2'b01;
      2'd2:    ab = 2'b10;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  function automatic int vec_cycles(input int settle);
    return settle + 2;
  endfunction

  function automatic int run_cycles(input int gates, input int settle);
    return NUM_PAT * gates * vec_cycles(settle);
  endfunction

endpackage

// File: rtl/or_gate_bist_ctrl_vecgen.sv
// Combinational vector generator: maps (gate, pattern) to the A/B drive
// words and the full-word Y value a healthy OR device must return.
module or_bist_vecgen
  import or_gate_bist_ctrl_pkg::*;
#(
  parameter int GATES = 3,
  parameter int GW    = 2
) (
  input  logic [GW-1:0]    gate_i,
  input  logic [1:0]       pat_i,
  output logic [GATES-1:0] a_o,
  output logic [GATES-1:0] b_o,
  output logic [GATES-1:0] exp_o
);

  logic [1:0] ab;
  assign ab = pat_ab(pat_i);

  for (genvar gi = 0; gi < GATES; gi++) begin : g_bit
    logic sel;
    assign sel       = (gate_i == GW'(gi));
    assign a_o[gi]   = sel & ab[1];
    assign b_o[gi]   = sel & ab[0];
    assign exp_o[gi] = sel & (ab[1] | ab[0]);
  end

endmodule

// File: rtl/or_gate_bist_ctrl.sv
// BIST sequencer for a multi-gate 2-input OR device: walks every gate through
// four patterns, waits a settle interval, checks Y and accumulates results.
module or_gate_bist_ctrl
  import or_gate_bist_ctrl_pkg::*;
#(
  parameter int GATES  = 3,
  parameter int SETTLE = 2,
  parameter int ERRW   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic [GATES-1:0] a_o,
  output logic [GATES-1:0] b_o,
  input  logic [GATES-1:0] y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [GATES-1:0] fail_mask_o,
  output logic [ERRW-1:0]  err_cnt_o
);

  localparam int GW = (GATES > 1) ? $clog2(GATES) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [GW-1:0] GATE_LAST   = GW'(GATES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e           state_q;
  logic [GW-1:0]    gate_q, gate_d;
  logic [1:0]       pat_q, pat_d;
  logic [CW-1:0]    cnt_q;
  logic [GATES-1:0] a_q, b_q, exp_q;
  logic             busy_q, done_q, pass_q;
  logic [GATES-1:0] mask_q, mask_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic [GATES-1:0] vec_a, vec_b, vec_e;
  logic             mismatch, last_vec;

  // Counters of the vector to be loaded next: the first vector when starting,
  // otherwise the successor of the one being checked.
  always_comb begin
    gate_d = '0;
    pat_d  = '0;
    if (state_q == ST_CHECK) begin
      gate_d = gate_q;
      if (pat_q == PAT_LAST) begin
        gate_d = gate_q + GW'(1);
      end else begin
        pat_d = pat_q + 2'd1;
      end
    end
  end

  assign last_vec = (pat_q == PAT_LAST) && (gate_q == GATE_LAST);
  assign mismatch = (y_i != exp_q);

  always_comb begin
    mask_d = mask_q;
    err_d  = err_q;
    if (mismatch) begin
      mask_d[gate_q] = 1'b1;
      if (!(&err_q)) begin
        err_d = err_q + ERRW'(1);
      end
    end
  end

  or_bist_vecgen #(
    .GATES (GATES),
    .GW    (GW)
  ) u_vecgen (
    .gate_i (gate_d),
    .pat_i  (pat_d),
    .a_o    (vec_a),
    .b_o    (vec_b),
    .exp_o  (vec_e)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FIN: begin
          if (start_i) begin
            mask_q  <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            gate_q  <= gate_d;
            pat_q   <= pat_d;
            a_q     <= vec_a;
            b_q     <= vec_b;
            exp_q   <= vec_e;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          cnt_q   <= '0;
          state_q <= (SETTLE > 0) ? ST_WAIT : ST_CHECK;
        end
        ST_WAIT: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_CHECK: begin
          mask_q <= mask_d;
          err_q  <= err_d;
          if (last_vec) begin
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= ST_FIN;
          end else begin
            gate_q  <= gate_d;
            pat_q   <= pat_d;
            a_q     <= vec_a;
            b_q     <= vec_b;
            exp_q   <= vec_e;
            state_q <= ST_DRIVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_mask_o = mask_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_or_gate_bist_ctrl.sv
// Bench for or_gate_bist_ctrl: a fault-injectable OR device model closes the
// loop; directed fault cases plus random faults checked against a pattern model.
module tb_or_gate_bist_ctrl;

  localparam int GATES  = 3;
  localparam int SETTLE = 2;
  localparam int ERRW   = 8;
  localparam int RUN    = 4 * GATES * (SETTLE + 2);

  logic             clk = 1'b0;
  logic             rst, start;
  logic [GATES-1:0] a, b, y;
  logic             busy, done, pass;
  logic [GATES-1:0] mask;
  logic [ERRW-1:0]  err;

  logic [GATES-1:0] sa0, sa1;
  logic             bridge;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [GATES-1:0] dev_y(input logic [GATES-1:0] va, input logic [GATES-1:0] vb,
                                             input logic [GATES-1:0] s0, input logic [GATES-1:0] s1,
                                             input logic br);
    logic [GATES-1:0] r;
    r = ((va | vb) & ~s0) | s1;
    if (br) r[0] = va[0] | vb[0] | va[1];
    return r;
  endfunction

  assign y = dev_y(a, b, sa0, sa1, bridge);

  or_gate_bist_ctrl #(
    .GATES  (GATES),
    .SETTLE (SETTLE),
    .ERRW   (ERRW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .a_o         (a),
    .b_o         (b),
    .y_i         (y),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .fail_mask_o (mask),
    .err_cnt_o   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: enumerate every (gate, pattern) vector and tally mismatches.
  task automatic model(output logic [GATES-1:0] m, output int e);
    logic [1:0]       order [4];
    logic [GATES-1:0] va, vb, yy;
    order = '{2'b11, 2'b01, 2'b10, 2'b00};
    m = '0;
    e = 0;
    for (int g = 0; g < GATES; g++) begin
      for (int p = 0; p < 4; p++) begin
        va = '0;
        vb = '0;
        va[g] = order[p][1];
        vb[g] = order[p][0];
        yy = dev_y(va, vb, sa0, sa1, bridge);
        if (yy != (va | vb)) begin
          m[g] = 1'b1;
          if (e < (2 ** ERRW) - 1) e++;
        end
      end
    end
  endtask

  task automatic run(input string tag, input logic [GATES-1:0] m_exp, input int e_exp, input bit noisy);
    int cyc;
    bit busy_ok;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    check({tag, " done_clr"}, 32'(done), 32'd0);
    check({tag, " busy_set"}, 32'(busy), 32'd1);
    check({tag, " res_clr"}, 32'({mask, err}), 32'd0);
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < RUN + 20) begin
      start = (noisy && cyc < RUN - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, " run_len"}, 32'(cyc), 32'(RUN));
    check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
    repeat (2) @(negedge clk);
    check({tag, " done"}, 32'({done, busy}), 32'b10);
    check({tag, " pass"}, 32'(pass), 32'(e_exp == 0));
    check({tag, " mask"}, 32'(mask), 32'(m_exp));
    check({tag, " err"}, 32'(err), 32'(e_exp));
    check({tag, " ab_zero"}, 32'({a, b}), 32'd0);
    $display("run %s: mask=%b err=%0d pass=%0b cycles=%0d", tag, mask, err, pass, cyc);
  endtask

  initial begin
    logic [GATES-1:0] m;
    int e;
    rst = 1'b1;
    start = 1'b0;
    sa0 = '0;
    sa1 = '0;
    bridge = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ab", 32'({a, b}), 32'd0);
    check("rst_flags", 32'({busy, done, pass}), 32'd0);
    check("rst_res", 32'({mask, err}), 32'd0);
    rst = 1'b0;

    run("golden", 3'b000, 0, 1'b0);
    sa0 = 3'b010;
    run("y1_sa0", 3'b010, 3, 1'b0);
    sa0 = 3'b000;
    sa1 = 3'b100;
    run("y2_sa1", 3'b111, 9, 1'b0);
    sa1 = 3'b000;
    bridge = 1'b1;
    run("bridge", 3'b010, 2, 1'b0);
    bridge = 1'b0;

    // Abort a faulty run at cycle 20, then a clean run must still pass.
    sa0 = 3'b010;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ab", 32'({a, b}), 32'd0);
    check("abort_flags", 32'({busy, done, pass}), 32'd0);
    check("abort_res", 32'({mask, err}), 32'd0);
    rst = 1'b0;
    sa0 = 3'b000;
    @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    run("after_abort", 3'b000, 0, 1'b0);

    run("start_noise", 3'b000, 0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      sa0 = GATES'($urandom);
      sa1 = GATES'($urandom);
      bridge = 1'($urandom_range(0, 1));
      model(m, e);
      run($sformatf("rand%0d", i), m, e, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
